// File: rtl/ysyx_rob.sv
// ysyx_rob -- in-order reorder buffer sitting after the rename unit.
//
// Renamed uops are accepted in program order and tagged with their entry
// index (the tail). Execute reports completion plus the resolved next PC
// by tag. The head entry retires on the commit channel once it is done;
// if its resolved next PC differs from the predicted one, a one-cycle
// flush is raised and the whole buffer is emptied on that edge.
//
// Ports:
//   clock, reset            rising-edge clock, async active-low reset
//   rnu_valid/ready/tag     dispatch handshake, tag = entry assigned
//   rnu_rd/prd/prs/pc/pnpc  uop fields captured at dispatch
//   wb_valid/tag/npc        execute completion with resolved next PC
//   cmu_valid, cmu_*        head entry retiring this cycle (+ its fields)
//   flush_pipe, flush_npc   mispredict at retire and redirect target
//
// Optional feature: define YSYX_ROB_WB_BYPASS_EN to let a writeback that
// targets the busy head entry retire it in the same cycle.
module ysyx_rob #(
    parameter  int ROB_SIZE = 8,
    parameter  int RLEN     = 5,
    parameter  int PLEN     = 6,
    parameter  int XLEN     = 32,
    localparam int TLEN     = $clog2(ROB_SIZE)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            rnu_valid,
    output logic            rnu_ready,
    input  logic [RLEN-1:0] rnu_rd,
    input  logic [PLEN-1:0] rnu_prd,
    input  logic [PLEN-1:0] rnu_prs,
    input  logic [XLEN-1:0] rnu_pc,
    input  logic [XLEN-1:0] rnu_pnpc,
    output logic [TLEN-1:0] rnu_tag,
    input  logic            wb_valid,
    input  logic [TLEN-1:0] wb_tag,
    input  logic [XLEN-1:0] wb_npc,
    output logic            cmu_valid,
    output logic [RLEN-1:0] cmu_rd,
    output logic [PLEN-1:0] cmu_prd,
    output logic [PLEN-1:0] cmu_prs,
    output logic [XLEN-1:0] cmu_pc,
    output logic            flush_pipe,
    output logic [XLEN-1:0] flush_npc
);

    localparam logic [TLEN:0]   FULL  = (TLEN+1)'(ROB_SIZE);
    localparam logic [TLEN-1:0] ONE_T = TLEN'(1);

    logic [ROB_SIZE-1:0] busy, done;
    logic [RLEN-1:0]     rd_q   [ROB_SIZE];
    logic [PLEN-1:0]     prd_q  [ROB_SIZE];
    logic [PLEN-1:0]     prs_q  [ROB_SIZE];
    logic [XLEN-1:0]     pc_q   [ROB_SIZE];
    logic [XLEN-1:0]     pnpc_q [ROB_SIZE];
    logic [XLEN-1:0]     npc_q  [ROB_SIZE];

    logic [TLEN-1:0] head, tail;
    logic [TLEN:0]   count;

    logic            byp;
    logic [XLEN-1:0] head_npc;
    logic            disp;

`ifdef YSYX_ROB_WB_BYPASS_EN
    assign byp = wb_valid && (wb_tag == head) && busy[head];
`else
    assign byp = 1'b0;
`endif

    // With bypass the completing writeback stands in for the stored npc.
    assign head_npc   = byp ? wb_npc : npc_q[head];

    assign rnu_ready  = (count != FULL);
    assign rnu_tag    = tail;
    assign cmu_valid  = busy[head] && (done[head] || byp);
    assign cmu_rd     = rd_q[head];
    assign cmu_prd    = prd_q[head];
    assign cmu_prs    = prs_q[head];
    assign cmu_pc     = pc_q[head];
    assign flush_pipe = cmu_valid && (head_npc != pnpc_q[head]);
    assign flush_npc  = flush_pipe ? head_npc : '0;

    assign disp = rnu_valid && rnu_ready && !flush_pipe;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy  <= '0;
            done  <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            // Data is cleared too so the head fields read 0 out of reset.
            for (int i = 0; i < ROB_SIZE; i++) begin
                rd_q[i]   <= '0;
                prd_q[i]  <= '0;
                prs_q[i]  <= '0;
                pc_q[i]   <= '0;
                pnpc_q[i] <= '0;
                npc_q[i]  <= '0;
            end
        end else if (flush_pipe) begin
            // Retiring uop leaves with the flush; dispatch/writeback dropped.
            busy  <= '0;
            done  <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (wb_valid && busy[wb_tag]) begin
                done[wb_tag]  <= 1'b1;
                npc_q[wb_tag] <= wb_npc;
            end
            // Commit after writeback so a bypassed head never keeps done set.
            if (cmu_valid) begin
                busy[head] <= 1'b0;
                done[head] <= 1'b0;
                head       <= head + ONE_T;
            end
            if (disp) begin
                busy[tail]   <= 1'b1;
                done[tail]   <= 1'b0;
                rd_q[tail]   <= rnu_rd;
                prd_q[tail]  <= rnu_prd;
                prs_q[tail]  <= rnu_prs;
                pc_q[tail]   <= rnu_pc;
                pnpc_q[tail] <= rnu_pnpc;
                npc_q[tail]  <= '0;
                tail         <= tail + ONE_T;
            end
            case ({disp, cmu_valid})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_rob.sv
// Self-checking bench for ysyx_rob: directed scenarios followed by random
// traffic, all compared against a queue-based model of the buffer.
module tb_ysyx_rob;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        rnu_valid = 1'b0;
    logic        rnu_ready;
    logic [4:0]  rnu_rd = '0;
    logic [5:0]  rnu_prd = '0, rnu_prs = '0;
    logic [31:0] rnu_pc = '0, rnu_pnpc = '0;
    logic [2:0]  rnu_tag;
    logic        wb_valid = 1'b0;
    logic [2:0]  wb_tag = '0;
    logic [31:0] wb_npc = '0;
    logic        cmu_valid;
    logic [4:0]  cmu_rd;
    logic [5:0]  cmu_prd, cmu_prs;
    logic [31:0] cmu_pc;
    logic        flush_pipe;
    logic [31:0] flush_npc;

    ysyx_rob dut (
        .clock(clock), .reset(reset),
        .rnu_valid(rnu_valid), .rnu_ready(rnu_ready),
        .rnu_rd(rnu_rd), .rnu_prd(rnu_prd), .rnu_prs(rnu_prs),
        .rnu_pc(rnu_pc), .rnu_pnpc(rnu_pnpc), .rnu_tag(rnu_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_npc(wb_npc),
        .cmu_valid(cmu_valid), .cmu_rd(cmu_rd), .cmu_prd(cmu_prd),
        .cmu_prs(cmu_prs), .cmu_pc(cmu_pc),
        .flush_pipe(flush_pipe), .flush_npc(flush_npc)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model: the buffer is simply the list of in-flight uops, oldest first.
    typedef struct {
        int          tag;
        logic [4:0]  rd;
        logic [5:0]  prd, prs;
        logic [31:0] pc, pnpc, npc;
        bit          done;
    } ent_t;

    ent_t q[$];
    int   m_tail = 0;

    task automatic set_uop(input logic [4:0] rd, input logic [5:0] prd, input logic [5:0] prs,
                           input logic [31:0] pc, input logic [31:0] pnpc);
        rnu_valid = 1'b1;
        rnu_rd = rd; rnu_prd = prd; rnu_prs = prs; rnu_pc = pc; rnu_pnpc = pnpc;
    endtask

    task automatic set_wb(input int tag, input logic [31:0] npc);
        wb_valid = 1'b1;
        wb_tag   = 3'(tag);
        wb_npc   = npc;
    endtask

    // Called at a negedge with inputs already driven: check the combinational
    // outputs, advance one clock edge, update the model, drop the requests.
    task automatic tick();
        bit          e_ready, e_cv, e_fl, hit;
        logic [31:0] e_npc, e_fnpc;
        ent_t        ne;
        #1;
        e_ready = (q.size() < 8);
        hit     = 1'b0;
        e_cv    = 1'b0;
        e_npc   = '0;
`ifdef YSYX_ROB_WB_BYPASS_EN
        hit = wb_valid && q.size() > 0 && int'(wb_tag) == q[0].tag;
`endif
        if (q.size() > 0) begin
            e_cv  = q[0].done || hit;
            e_npc = hit ? wb_npc : q[0].npc;
        end
        e_fl   = e_cv && (e_npc != q[0].pnpc);
        e_fnpc = e_fl ? e_npc : 32'h0;
        chk("rnu_ready", rnu_ready, e_ready);
        chk("rnu_tag", rnu_tag, m_tail);
        chk("cmu_valid", cmu_valid, e_cv);
        chk("flush_pipe", flush_pipe, e_fl);
        chk("flush_npc", flush_npc, e_fnpc);
        if (e_cv) begin
            chk("cmu_rd", cmu_rd, q[0].rd);
            chk("cmu_prd", cmu_prd, q[0].prd);
            chk("cmu_prs", cmu_prs, q[0].prs);
            chk("cmu_pc", cmu_pc, q[0].pc);
        end
        @(posedge clock);
        if (e_fl) begin
            q.delete();
            m_tail = 0;
        end else begin
            if (wb_valid)
                foreach (q[i])
                    if (q[i].tag == int'(wb_tag)) begin
                        q[i].done = 1'b1;
                        q[i].npc  = wb_npc;
                    end
            if (e_cv) void'(q.pop_front());
            if (rnu_valid && e_ready) begin
                ne.tag = m_tail; ne.rd = rnu_rd; ne.prd = rnu_prd; ne.prs = rnu_prs;
                ne.pc = rnu_pc; ne.pnpc = rnu_pnpc; ne.npc = '0; ne.done = 1'b0;
                q.push_back(ne);
                m_tail = (m_tail + 1) % 8;
            end
        end
        @(negedge clock);
        rnu_valid = 1'b0;
        wb_valid  = 1'b0;
    endtask

    // Assert reset at a negedge and check outputs before any clock edge.
    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("rst_ready", rnu_ready, 1'b1);
        chk("rst_tag", rnu_tag, 3'd0);
        chk("rst_cmu_valid", cmu_valid, 1'b0);
        chk("rst_flush", flush_pipe, 1'b0);
        chk("rst_flush_npc", flush_npc, 32'h0);
        chk("rst_cmu_fields", {cmu_rd, cmu_prd, cmu_prs, cmu_pc}, 49'h0);
        q.delete();
        m_tail = 0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        @(negedge clock);
        do_reset();

        // In-order commit despite out-of-order writeback.
        for (int i = 0; i < 3; i++) begin
            set_uop(5'(i + 1), 6'(32 + i), 6'(i + 1), 32'(32'h1000 + 4 * i), 32'(32'h1004 + 4 * i));
            tick();
        end
        set_wb(2, 32'h100c); tick();
        set_wb(0, 32'h1004); tick();
        set_wb(1, 32'h1008); tick();
        repeat (3) tick();

        // Fill, stall while full, commit one, wrap the tail.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_uop(5'(i), 6'(i), 6'(i), 32'(16 * i), 32'(16 * i + 4));
            tick();
        end
        set_uop(5'd9, 6'd9, 6'd9, 32'h900, 32'h904);
        chk("full_not_ready", rnu_ready, 1'b0);
        set_wb(0, 32'h4);
        tick();
        set_uop(5'd9, 6'd9, 6'd9, 32'h900, 32'h904);
        tick();
        set_uop(5'd10, 6'd10, 6'd10, 32'ha00, 32'ha04);
        chk("wrap_tag", rnu_tag, 3'd0);
        tick();

        // Mispredict flush; dispatch in the flush cycle is dropped.
        do_reset();
        set_uop(5'd1, 6'd40, 6'd1, 32'h100, 32'h104); tick();
        set_wb(0, 32'h200); tick();
        set_uop(5'd2, 6'd41, 6'd2, 32'h200, 32'h204);
        set_wb(0, 32'h300);
        #1;
        chk("flush_seen", flush_pipe, 1'b1);
        chk("flush_target", flush_npc, 32'h200);
        tick();
        set_uop(5'd2, 6'd41, 6'd2, 32'h200, 32'h204);
        chk("post_flush_tag", rnu_tag, 3'd0);
        tick();
        tick();

        // Dispatch and commit together at count=4.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_uop(5'(i), 6'(i), 6'(i), 32'(8 * i), 32'(8 * i + 4));
            tick();
        end
        set_wb(0, 32'h4); tick();
        set_uop(5'd7, 6'd7, 6'd7, 32'h700, 32'h704); tick();
        set_uop(5'd8, 6'd8, 6'd8, 32'h800, 32'h804);
        chk("cnt4_tag", rnu_tag, 3'd5);
        tick();

        // Writeback to a free entry leaves no trace.
        do_reset();
        for (int i = 0; i < 2; i++) begin
            set_uop(5'(i), 6'(i), 6'(i), 32'(8 * i), 32'(8 * i + 4));
            tick();
        end
        set_wb(5, 32'h55); tick();
        for (int i = 2; i < 6; i++) begin
            set_uop(5'(i), 6'(i), 6'(i), 32'(8 * i), 32'(8 * i + 4));
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            set_wb(i, 32'(8 * i + 4));
            tick();
        end
        repeat (4) tick();
        chk("stale_done", cmu_valid, 1'b0);

        // Reset mid-stream with 5 busy entries.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_uop(5'(i), 6'(i), 6'(i), 32'(8 * i), 32'(8 * i + 4));
            tick();
        end
        do_reset();

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(3) != 0) begin
                logic [31:0] pc;
                pc = $urandom & 32'hffff_fffc;
                set_uop(5'($urandom), 6'($urandom), 6'($urandom), pc, pc + 32'd4);
            end
            if ($urandom_range(2) != 0) begin
                if (q.size() > 0 && $urandom_range(4) != 0) begin
                    int k;
                    k = $urandom_range(q.size() - 1);
                    set_wb(q[k].tag, ($urandom_range(15) == 0) ? $urandom : q[k].pnpc);
                end else begin
                    set_wb(int'($urandom_range(7)), $urandom);
                end
            end
            tick();
            if ($urandom_range(499) == 0) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
